// File: rtl/cache_arb_pkg.sv
// Shared types and helpers for the cache-port arbiter.
package cache_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2,
        RESP      = 2'd3
    } arb_state_e;

    // Watchdog counter must be able to hold the full TIMEOUT_CYCLES value.
    function automatic int tmo_cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/cache_arbiter_rr.sv
// Combinational round-robin pick: first set request at or after the pointer.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
    output logic [$clog2(NUM_REQ)-1:0] o_grant,
    output logic                       o_any
);

    localparam int IDX_W = $clog2(NUM_REQ);

    int w_idx;

    // Scan from the farthest offset down so the closest requester wins last.
    always_comb begin
        o_grant = '0;
        o_any   = |i_req;
        w_idx   = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = int'(i_ptr) + k;
            if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
            if (i_req[w_idx]) o_grant = IDX_W'(w_idx);
        end
    end

endmodule

// File: rtl/cache_arbiter.sv
// Round-robin share of the cache_wrapper CPU port between NUM_REQ masters,
// one transaction in flight, with a watchdog that completes stuck requests.
module cache_arbiter
    import cache_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NUM_REQ-1:0]                   req_valid_i,
    output logic [NUM_REQ-1:0]                   req_ready_o,
    input  logic [NUM_REQ-1:0]                   req_we_i,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_adr_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_wdata_i,
    output logic [DATA_WIDTH-1:0]                req_rdata_o,
    output logic [NUM_REQ-1:0]                   req_resp_valid_o,
    output logic                                 req_err_o,
    output logic                                 cache_valid_o,
    input  logic                                 cache_ready_i,
    output logic                                 cache_we_o,
    output logic [ADDR_WIDTH-1:0]                cache_adr_o,
    output logic [DATA_WIDTH-1:0]                cache_wdata_o,
    input  logic [DATA_WIDTH-1:0]                cache_rdata_i,
    input  logic                                 cache_resp_valid_i
);

    localparam int                IDX_W    = $clog2(NUM_REQ);
    localparam int                CNT_W    = tmo_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_REQ - 1);

    arb_state_e             r_state;
    logic [IDX_W-1:0]       r_ptr;
    logic [IDX_W-1:0]       r_grant;
    logic                   r_we;
    logic [ADDR_WIDTH-1:0]  r_adr;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic [DATA_WIDTH-1:0]  r_rdata;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_tmo;
    logic [NUM_REQ-1:0]     r_ready;

    logic [IDX_W-1:0]       w_pick;
    logic                   w_any;
    logic                   w_expired;
    logic                   w_resp;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .i_req   (req_valid_i),
        .i_ptr   (r_ptr),
        .o_grant (w_pick),
        .o_any   (w_any)
    );

    // Counter may already sit past the limit if ready came on the last cycle.
    assign w_expired = (r_cnt >= TMO_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_grant <= '0;
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_cnt   <= '0;
            r_tmo   <= 1'b0;
            r_ready <= '0;
        end else begin
            r_ready <= '0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant <= w_pick;
                        r_we    <= req_we_i[w_pick];
                        r_adr   <= req_adr_i[w_pick];
                        r_wdata <= req_wdata_i[w_pick];
                        r_ready <= NUM_REQ'(1) << w_pick;
                        r_cnt   <= '0;
                        r_tmo   <= 1'b0;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (cache_ready_i && cache_resp_valid_i) begin
                        r_rdata <= cache_rdata_i;
                        r_state <= RESP;
                    end else if (cache_ready_i) begin
                        r_state <= WAIT_RESP;
                    end else if (w_expired) begin
                        r_rdata <= '0;
                        r_tmo   <= 1'b1;
                        r_state <= RESP;
                    end
                end
                WAIT_RESP: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (cache_resp_valid_i) begin
                        r_rdata <= cache_rdata_i;
                        r_state <= RESP;
                    end else if (w_expired) begin
                        r_rdata <= '0;
                        r_tmo   <= 1'b1;
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    r_ptr   <= (r_grant == IDX_LAST) ? '0 : r_grant + 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_resp           = (r_state == RESP);
    assign cache_valid_o    = (r_state == ISSUE);
    assign cache_we_o       = r_we;
    assign cache_adr_o      = r_adr;
    assign cache_wdata_o    = r_wdata;
    assign req_ready_o      = r_ready;
    assign req_rdata_o      = r_rdata;
    assign req_resp_valid_o = w_resp ? (NUM_REQ'(1) << r_grant) : '0;
    assign req_err_o        = w_resp & r_tmo;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: single ops, contention, timeout, fast path, reset.
module tb_cache_arbiter;

    localparam int NR  = 2;
    localparam int AW  = 16;
    localparam int DW  = 32;
    localparam int TMO = 8;

    logic                  clk_i = 1'b0;
    logic                  rst_ni = 1'b0;
    logic [NR-1:0]         req_valid_i;
    logic [NR-1:0]         req_ready_o;
    logic [NR-1:0]         req_we_i;
    logic [NR-1:0][AW-1:0] req_adr_i;
    logic [NR-1:0][DW-1:0] req_wdata_i;
    logic [DW-1:0]         req_rdata_o;
    logic [NR-1:0]         req_resp_valid_o;
    logic                  req_err_o;
    logic                  cache_valid_o;
    logic                  cache_ready_i;
    logic                  cache_we_o;
    logic [AW-1:0]         cache_adr_o;
    logic [DW-1:0]         cache_wdata_o;
    logic [DW-1:0]         cache_rdata_i;
    logic                  cache_resp_valid_i;

    always #5 clk_i = ~clk_i;

    cache_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_adr_i(req_adr_i), .req_wdata_i(req_wdata_i), .req_rdata_o(req_rdata_o),
        .req_resp_valid_o(req_resp_valid_o), .req_err_o(req_err_o),
        .cache_valid_o(cache_valid_o), .cache_ready_i(cache_ready_i), .cache_we_o(cache_we_o),
        .cache_adr_o(cache_adr_o), .cache_wdata_o(cache_wdata_o), .cache_rdata_i(cache_rdata_i),
        .cache_resp_valid_i(cache_resp_valid_i)
    );

    int            n_vec = 0;
    int            n_bad = 0;
    int            cv_cycles = 0;
    int            cv_rises = 0;
    int            resp_evt = 0;
    int            resp_cnt [NR] = '{default: 0};
    int            gseq[$];
    int            s_lat = 0;
    logic          cv_prev = 1'b0;
    logic [NR-1:0] last_resp = '0;
    logic [DW-1:0] last_rdata = '0;
    logic          last_err = 1'b0;
    logic          c_we = 1'b0;
    logic [AW-1:0] c_adr = '0;
    logic [DW-1:0] c_wdata = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_rst(input string tag);
        check({tag, "_ctl"}, 64'({req_ready_o, req_resp_valid_o, req_err_o, cache_valid_o, cache_we_o}), 64'(0));
        check({tag, "_bus"}, 64'({cache_adr_o, cache_wdata_o}), 64'(0));
        check({tag, "_rdata"}, 64'(req_rdata_o), 64'(0));
    endtask

    // One clock, then sample outputs and play the requester side (drop valid on ready).
    task automatic tick();
        @(posedge clk_i);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (req_ready_o[i]) begin
                req_valid_i[i] = 1'b0;
                gseq.push_back(i);
            end
        end
        if (cache_valid_o) cv_cycles++;
        if (cache_valid_o && !cv_prev) cv_rises++;
        cv_prev = cache_valid_o;
        if (|req_resp_valid_o) begin
            resp_evt++;
            last_resp  = req_resp_valid_o;
            last_rdata = req_rdata_o;
            last_err   = req_err_o;
            for (int i = 0; i < NR; i++) if (req_resp_valid_o[i]) resp_cnt[i]++;
        end
    endtask

    // Cache-side model: accept after rdy_dly cycles, respond resp_dly cycles later (0 = same cycle).
    task automatic serve(input int rdy_dly, input int resp_dly, input logic [DW-1:0] rd, input bit hang);
        int n;
        int ev0;
        n = 0;
        while (!cache_valid_o && n < 40) begin tick(); n++; end
        check("cache_valid_seen", 64'(cache_valid_o), 64'(1));
        if (!cache_valid_o) return;
        c_we = cache_we_o; c_adr = cache_adr_o; c_wdata = cache_wdata_o;
        ev0 = resp_evt;
        s_lat = 0;
        repeat (rdy_dly) tick();
        if (!hang) begin
            cache_ready_i = 1'b1;
            if (resp_dly == 0) begin cache_resp_valid_i = 1'b1; cache_rdata_i = rd; end
            tick(); s_lat++;
            cache_ready_i = 1'b0; cache_resp_valid_i = 1'b0;
            if (resp_dly > 0) begin
                repeat (resp_dly - 1) begin tick(); s_lat++; end
                cache_resp_valid_i = 1'b1; cache_rdata_i = rd;
                tick(); s_lat++;
                cache_resp_valid_i = 1'b0;
            end
        end
        n = 0;
        while (resp_evt == ev0 && n < 40) begin tick(); s_lat++; n++; end
        check("resp_seen", 64'(resp_evt - ev0), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            cr0;
        int            cc0;
        int            n0;
        int            n;
        logic [1:0]    e_own;
        req_valid_i = '0; req_we_i = '0; req_adr_i = '0; req_wdata_i = '0;
        cache_ready_i = 1'b0; cache_resp_valid_i = 1'b0; cache_rdata_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        check_rst("reset");
        rst_ni = 1'b1;
        tick();

        // Single write from R0, cache ready after 3 cycles, response 1 later
        req_we_i[0] = 1'b1; req_adr_i[0] = 16'h0010; req_wdata_i[0] = 32'hDEADBEEF; req_valid_i[0] = 1'b1;
        cr0 = cv_rises;
        serve(3, 1, 32'h0, 1'b0);
        check("t1_we", 64'(c_we), 64'(1));
        check("t1_adr", 64'(c_adr), 64'(16'h0010));
        check("t1_wdata", 64'(c_wdata), 64'(32'hDEADBEEF));
        check("t1_valid_once", 64'(cv_rises - cr0), 64'(1));
        check("t1_resp_r0", 64'(resp_cnt[0]), 64'(1));
        check("t1_resp_r1", 64'(resp_cnt[1]), 64'(0));
        check("t1_err", 64'(last_err), 64'(0));
        check("t1_ready_dropped", 64'(req_valid_i[0]), 64'(0));
        tick();

        // Single read from R1
        req_we_i[1] = 1'b0; req_adr_i[1] = 16'h0020; req_valid_i[1] = 1'b1;
        serve(0, 2, 32'hBEEF0020, 1'b0);
        check("t2_we", 64'(c_we), 64'(0));
        check("t2_adr", 64'(c_adr), 64'(16'h0020));
        check("t2_rdata", 64'(last_rdata), 64'(32'hBEEF0020));
        check("t2_owner", 64'(last_resp), 64'(2'b10));
        check("t2_r0_quiet", 64'(resp_cnt[0]), 64'(1));
        tick();

        // Contention: both hold valid, expect R0,R1,R0,R1
        gseq.delete();
        req_we_i = '0; req_adr_i[0] = 16'h0100; req_adr_i[1] = 16'h0200; req_valid_i = 2'b11;
        for (int k = 0; k < 4; k++) begin
            serve(1, 1, 32'hC0DE0000 + k, 1'b0);
            e_own = 2'b01 << (k % 2);
            check("t3_owner", 64'(last_resp), 64'(e_own));
            check("t3_adr", 64'(c_adr), 64'((k % 2) ? 16'h0200 : 16'h0100));
            check("t3_rdata", 64'(last_rdata), 64'(32'hC0DE0000 + k));
            if (k < 2) req_valid_i[k % 2] = 1'b1;
        end
        check("t3_grants", 64'(gseq.size()), 64'(4));
        check("t3_totals", 64'({resp_cnt[0], resp_cnt[1]}), 64'({32'd3, 32'd3}));
        tick();

        // Timeout: cache never ready
        req_adr_i[1] = 16'h0030; req_valid_i[1] = 1'b1;
        cc0 = cv_cycles;
        serve(0, 0, 32'hFFFFFFFF, 1'b1);
        check("t4_valid_cycles", 64'(cv_cycles - cc0), 64'(TMO));
        check("t4_err", 64'(last_err), 64'(1));
        check("t4_rdata", 64'(last_rdata), 64'(0));
        check("t4_owner", 64'(last_resp), 64'(2'b10));
        check("t4_valid_dropped", 64'(cache_valid_o), 64'(0));
        tick();
        req_adr_i[0] = 16'h0040; req_valid_i[0] = 1'b1;
        serve(1, 1, 32'h55AA55AA, 1'b0);
        check("t4b_err", 64'(last_err), 64'(0));
        check("t4b_rdata", 64'(last_rdata), 64'(32'h55AA55AA));
        check("t4b_owner", 64'(last_resp), 64'(2'b01));
        tick();

        // Ready and response in the same cycle skip WAIT_RESP
        req_adr_i[0] = 16'h0050; req_valid_i[0] = 1'b1;
        serve(0, 0, 32'h12345678, 1'b0);
        check("t5_latency", 64'(s_lat), 64'(1));
        check("t5_rdata", 64'(last_rdata), 64'(32'h12345678));
        check("t5_owner", 64'(last_resp), 64'(2'b01));
        tick();

        // Reset while R1 waits for its response
        n0 = resp_cnt[1];
        req_adr_i[1] = 16'h0060; req_valid_i[1] = 1'b1;
        n = 0;
        while (!cache_valid_o && n < 40) begin tick(); n++; end
        check("t6_issued", 64'(cache_valid_o), 64'(1));
        cache_ready_i = 1'b1;
        tick();
        cache_ready_i = 1'b0;
        check("t6_in_wait", 64'(cache_valid_o), 64'(0));
        #2 rst_ni = 1'b0;
        #1 check_rst("t6_reset");
        @(negedge clk_i);
        rst_ni = 1'b1;
        cache_resp_valid_i = 1'b1; cache_rdata_i = 32'hBAD0BAD0;
        tick();
        cache_resp_valid_i = 1'b0;
        repeat (3) tick();
        check("t6_no_stale", 64'(resp_cnt[1] - n0), 64'(0));
        gseq.delete();
        req_adr_i[0] = 16'h0070; req_adr_i[1] = 16'h0080; req_valid_i = 2'b11;
        serve(0, 1, 32'hA5A5A5A5, 1'b0);
        check("t6_first_grant", 64'(gseq.size() > 0 ? gseq[0] : 99), 64'(0));
        check("t6_owner", 64'(last_resp), 64'(2'b01));
        check("t6_adr", 64'(c_adr), 64'(16'h0070));
        serve(0, 1, 32'h5A5A5A5A, 1'b0);
        check("t6_second_owner", 64'(last_resp), 64'(2'b10));
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
